ysyx_23060061_axi_lite_sram: RTL and testbench

AXI-lite responder (slave) memory serving the IFU/LSU read and write channels. It accepts one read and one write transaction at a time. It models configurable access latency and returns data/responses with full valid/ready handshakes. It sits on the far side of the fetch/memory interface and replaces the DPI paddr_read path with a synthesizable, cycle-accurate memory.

---
 rtl/ysyx_23060061_axi_pkg.sv | 29 ++
 rtl/ysyx_23060061_sram_array.sv | 42 ++++
 rtl/ysyx_23060061_axi_lite_sram.sv | 229 ++++++++++++++++++++++
 tb/tb_ysyx_23060061_axi_lite_sram.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060061_axi_pkg.sv
// ============================================================================
// Module  : ysyx_23060061_axi_pkg
// Brief   : Shared response codes, FSM state encodings and default base
//           address for the AXI-lite SRAM responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_23060061_axi_pkg;

  localparam logic        RESP_OKAY = 1'b0;
  localparam logic        RESP_ERR  = 1'b1;
  localparam logic [31:0] SRAM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    B_RESP = 2'd2
  } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060061_sram_array.sv
// ============================================================================
// Module  : ysyx_23060061_sram_array
// Brief   : DEPTH x 32 storage, byte-enabled write port and synchronous read
//           port; a same-edge read of the written word returns the old data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060061_sram_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // One narrow array per byte lane maps directly onto byte-enabled RAM macros.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (we && wstrb[i]) begin
        r_mem[waddr] <= wdata[8*i +: 8];
      end
      if (re) begin
        r_q <= r_mem[raddr];
      end
    end

    assign rdata[8*i +: 8] = r_q;
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060061_axi_lite_sram.sv
// ============================================================================
// Module  : ysyx_23060061_axi_lite_sram
// Brief   : AXI-lite responder memory with independent read/write FSMs and
//           configurable latency. Define SRAM_RAND_DELAY_EN to add 0..7
//           LFSR-driven extra cycles per transaction.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060061_axi_lite_sram
  import ysyx_23060061_axi_pkg::*;
#(
  parameter int          DEPTH  = 4096,
  parameter logic [31:0] BASE   = SRAM_BASE,
  parameter int          RD_LAT = 1,
  parameter int          WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] c_span = 33'(DEPTH) << 2;

  rd_state_t   r_rstate;
  logic [4:0]  r_rcnt;
  logic [31:0] r_araddr;
  logic        r_arready;
  logic        r_rvalid;
  logic        r_rresp;
  logic        r_rdata_en;

  wr_state_t   r_wstate;
  logic [4:0]  r_wcnt;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic        r_bresp;

  logic [4:0]  w_rd_load;
  logic [4:0]  w_wr_load;

`ifdef SRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_rd_load = 5'(RD_LAT) + {2'b00, r_lfsr[2:0]};
  assign w_wr_load = 5'(WR_LAT) + {2'b00, r_lfsr[2:0]};
`else
  assign w_rd_load = 5'(RD_LAT);
  assign w_wr_load = 5'(WR_LAT);
`endif

  // Address decode for the latched read and write addresses.
  logic [31:0] w_rd_off;
  logic [31:0] w_wr_off;
  logic        w_rd_in;
  logic        w_wr_in;

  assign w_rd_off = r_araddr - BASE;
  assign w_wr_off = r_awaddr - BASE;
  assign w_rd_in  = ({1'b0, w_rd_off} < c_span);
  assign w_wr_in  = ({1'b0, w_wr_off} < c_span);

  // The wait state counts down to zero; the edge leaving it samples/commits.
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_sram_re;
  logic w_sram_we;
  logic [31:0] w_sram_q;

  assign w_rd_fire = (r_rstate == R_WAIT) && (r_rcnt == 5'd0);
  assign w_wr_fire = (r_wstate == W_WAIT) && (r_wcnt == 5'd0);
  assign w_sram_re = w_rd_fire && w_rd_in;
  assign w_sram_we = w_wr_fire && w_wr_in && rst;

  ysyx_23060061_sram_array #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_array (
    .clk   (clk),
    .we    (w_sram_we),
    .waddr (w_wr_off[c_aw+1:2]),
    .wdata (r_wdata),
    .wstrb (r_wstrb),
    .re    (w_sram_re),
    .raddr (w_rd_off[c_aw+1:2]),
    .rdata (w_sram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rstate   <= R_IDLE;
      r_rcnt     <= 5'd0;
      r_araddr   <= 32'h0;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata_en <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && r_arready) begin
            r_araddr  <= araddr;
            r_rcnt    <= w_rd_load;
            r_arready <= 1'b0;
            r_rstate  <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rcnt == 5'd0) begin
            r_rvalid   <= 1'b1;
            r_rresp    <= w_rd_in ? RESP_OKAY : RESP_ERR;
            r_rdata_en <= w_rd_in;
            r_rstate   <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - 5'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // AW and W are latched independently; a dropped ready marks a held beat.
  logic w_aw_hs;
  logic w_w_hs;
  logic w_both;

  assign w_aw_hs = awvalid && r_awready;
  assign w_w_hs  = wvalid && r_wready;
  assign w_both  = (!r_awready || w_aw_hs) && (!r_wready || w_w_hs);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_wcnt    <= 5'd0;
      r_awaddr  <= 32'h0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= awaddr;
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
            r_wready <= 1'b0;
          end
          if (w_both) begin
            r_wcnt   <= w_wr_load;
            r_wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (r_wcnt == 5'd0) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_in ? RESP_OKAY : RESP_ERR;
            r_wstate <= B_RESP;
          end else begin
            r_wcnt <= r_wcnt - 5'd1;
          end
        end
        B_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata_en ? w_sram_q : 32'h0;
  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060061_axi_lite_sram.sv
// ============================================================================
// Module  : tb_ysyx_23060061_axi_lite_sram
// Brief   : Directed self-checking bench for the AXI-lite SRAM responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060061_axi_lite_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = 32'h0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] awaddr = 32'h0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_23060061_axi_lite_sram #(
    .DEPTH  (4096),
    .BASE   (32'h8000_0000),
    .RD_LAT (1),
    .WR_LAT (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 clk = ~clk;

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic resp, output int lat);
    int t;
    araddr  = addr;
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    data = rdata;
    resp = rresp;
    if (rvalid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic resp, output int lat);
    int t;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    t = 0;
    while (!(awready && wready) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    resp = bresp;
    if (bvalid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    arvalid = 1'b1;
    araddr  = 32'h8000_0000;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (arready !== 1'b1) $display("FAIL reset_arready: got %b want 1", arready); else n_pass++;
    n_checks++; if (awready !== 1'b1) $display("FAIL reset_awready: got %b want 1", awready); else n_pass++;
    n_checks++; if (wready !== 1'b1) $display("FAIL reset_wready: got %b want 1", wready); else n_pass++;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else n_pass++;
    n_checks++; if (bvalid !== 1'b0) $display("FAIL reset_bvalid: got %b want 0", bvalid); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata); else n_pass++;
    n_checks++; if (rresp !== 1'b0 || bresp !== 1'b0) $display("FAIL reset_resp: got r=%b b=%b want 0/0", rresp, bresp); else n_pass++;
    arvalid = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++; if (rvalid !== 1'b0 || arready !== 1'b1) $display("FAIL reset_no_accept: got rvalid=%b arready=%b want 0/1", rvalid, arready); else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic r; int lat;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
    n_checks++; if (r !== 1'b0) $display("FAIL wr_bresp: got %b want 0", r); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL wr_latency: got %0d want 2", lat); else n_pass++;
    do_read(32'h8000_0010, d, r, lat);
    n_checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", d); else n_pass++;
    n_checks++; if (r !== 1'b0) $display("FAIL rd_rresp: got %b want 0", r); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL rd_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (arready !== 1'b1 || rvalid !== 1'b0) $display("FAIL rd_return_idle: got arready=%b rvalid=%b want 1/0", arready, rvalid); else n_pass++;
  endtask

  task automatic test_byte_strobe();
    logic [31:0] d; logic r; int lat;
    awaddr = 32'h8000_0010;
    wdata  = 32'h1122_3344;
    wstrb  = 4'b0101;
    wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    n_checks++; if (wready !== 1'b0 || awready !== 1'b1) $display("FAIL strb_w_first_ready: got wready=%b awready=%b want 0/1", wready, awready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bvalid !== 1'b0) $display("FAIL strb_no_early_b: got %b want 0", bvalid); else n_pass++;
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++; if (lat != 2 || bresp !== 1'b0) $display("FAIL strb_bresp: got lat=%0d bresp=%b want 2/0", lat, bresp); else n_pass++;
    @(posedge clk); #1;
    do_read(32'h8000_0010, d, r, lat);
    n_checks++; if (d !== 32'hDE22_BE44) $display("FAIL strb_data: got %h want de22be44", d); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    int t;
    rready  = 1'b0;
    araddr  = 32'h8000_0010;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    d0 = rdata;
    n_checks++; if (d0 !== 32'hDE22_BE44) $display("FAIL bp_first_data: got %h want de22be44", d0); else n_pass++;
    repeat (5) begin
      @(posedge clk); #1;
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'hDE22_BE44 || arready !== 1'b0)
        $display("FAIL bp_hold: got rvalid=%b rdata=%h arready=%b want 1/de22be44/0", rvalid, rdata, arready);
      else n_pass++;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (arready !== 1'b1 || rvalid !== 1'b0) $display("FAIL bp_release: got arready=%b rvalid=%b want 1/0", arready, rvalid); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic r; int lat;
    do_write(32'h8000_0000, 32'h0123_4567, 4'hF, r, lat);
    n_checks++; if (r !== 1'b0) $display("FAIL oor_base_bresp: got %b want 0", r); else n_pass++;
    do_read(32'h7FFF_FFFC, d, r, lat);
    n_checks++; if (r !== 1'b1 || d !== 32'h0) $display("FAIL oor_low_read: got rresp=%b rdata=%h want 1/00000000", r, d); else n_pass++;
    do_write(32'h8000_4000, 32'hCAFE_F00D, 4'hF, r, lat);
    n_checks++; if (r !== 1'b1) $display("FAIL oor_write_bresp: got %b want 1", r); else n_pass++;
    do_read(32'h8000_0000, d, r, lat);
    n_checks++; if (r !== 1'b0 || d !== 32'h0123_4567) $display("FAIL oor_mem_intact: got rresp=%b rdata=%h want 0/01234567", r, d); else n_pass++;
    do_read(32'h8000_4000, d, r, lat);
    n_checks++; if (r !== 1'b1 || d !== 32'h0) $display("FAIL oor_high_read: got rresp=%b rdata=%h want 1/00000000", r, d); else n_pass++;
    do_write(32'h8000_3FFF, 32'h5A5A_0001, 4'hF, r, lat);
    n_checks++; if (r !== 1'b0) $display("FAIL top_word_bresp: got %b want 0", r); else n_pass++;
    do_read(32'h8000_3FFC, d, r, lat);
    n_checks++; if (r !== 1'b0 || d !== 32'h5A5A_0001) $display("FAIL top_word_read: got rresp=%b rdata=%h want 0/5a5a0001", r, d); else n_pass++;
  endtask

  task automatic test_strobe_zero();
    logic [31:0] d; logic r; int lat;
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, r, lat);
    n_checks++; if (r !== 1'b0) $display("FAIL strb0_bresp: got %b want 0", r); else n_pass++;
    do_read(32'h8000_0010, d, r, lat);
    n_checks++; if (d !== 32'hDE22_BE44) $display("FAIL strb0_data: got %h want de22be44", d); else n_pass++;
  endtask

  task automatic test_collision();
    logic [31:0] d; logic r; int lat;
    do_write(32'h8000_0020, 32'hAAAA_5555, 4'hF, r, lat);
    araddr  = 32'h8000_0020;
    arvalid = 1'b1;
    awaddr  = 32'h8000_0020;
    wdata   = 32'h1234_5678;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0) $display("FAIL coll_early: got rvalid=%b bvalid=%b want 0/0", rvalid, bvalid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rvalid !== 1'b1 || bvalid !== 1'b1) $display("FAIL coll_same_edge: got rvalid=%b bvalid=%b want 1/1", rvalid, bvalid); else n_pass++;
    n_checks++; if (rdata !== 32'hAAAA_5555) $display("FAIL coll_old_data: got %h want aaaa5555", rdata); else n_pass++;
    @(posedge clk); #1;
    do_read(32'h8000_0020, d, r, lat);
    n_checks++; if (d !== 32'h1234_5678) $display("FAIL coll_new_data: got %h want 12345678", d); else n_pass++;
  endtask

  task automatic test_midop_reset();
    logic [31:0] d; logic r; int lat;
    araddr  = 32'h8000_0020;
    arvalid = 1'b1;
    awaddr  = 32'h8000_0020;
    wdata   = 32'hFFFF_FFFF;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) begin
      n_checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0) $display("FAIL midrst_no_valid: got rvalid=%b bvalid=%b want 0/0", rvalid, bvalid); else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++; if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1)
      $display("FAIL midrst_idle: got arready=%b awready=%b wready=%b want 1/1/1", arready, awready, wready);
    else n_pass++;
    do_read(32'h8000_0020, d, r, lat);
    n_checks++; if (d !== 32'h1234_5678) $display("FAIL midrst_write_dropped: got %h want 12345678", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_backpressure();
    test_out_of_range();
    test_strobe_zero();
    test_collision();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
